// File: rtl/oci_dct_pkg.sv
// Shared constants and FSM state type for the OCI trace symbol packer.
package oci_dct_pkg;
    localparam int SYM_W = 2;
    localparam int DEPTH = 15;
    localparam int BUF_W = SYM_W * DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        ENDED = 2'd2
    } dct_state_t;
endpackage

// File: rtl/oci_dct_outreg.sv
// One-entry valid/ready holding register for a packed word and its symbol count.
module oci_dct_outreg #(
    parameter int DATA_W = oci_dct_pkg::BUF_W,
    parameter int CNT_W  = oci_dct_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              free_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;

    // A load may coincide with the handshake of the previous word.
    assign free_o = !valid_q || ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            count_q <= count_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;
endmodule

// File: rtl/parameters.sv
// OCI trace symbol packer: accumulates symbols into words, flushes a partial word
// at end of trace and reports test_ending / test_has_ended downstream.
module parameters #(
    parameter int SYM_W = oci_dct_pkg::SYM_W,
    parameter int DEPTH = oci_dct_pkg::DEPTH,
    localparam int BUF_W = SYM_W * DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             test_ending,
    output logic             test_has_ended
);
    import oci_dct_pkg::dct_state_t;
    import oci_dct_pkg::RUN;
    import oci_dct_pkg::FLUSH;
    import oci_dct_pkg::ENDED;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam int               LAST_LSB  = (DEPTH - 1) * SYM_W;

    dct_state_t       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ld;
    logic [BUF_W-1:0] ld_data;
    logic [CNT_W-1:0] ld_cnt;
    logic             free;
    logic             at_last;
    logic             accept;

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // valid/data are held by the producer until then, ready never depends on valid.
    assign at_last   = (cnt_q == LAST_SLOT);
    assign sym_ready = (state_q == RUN) && !(at_last && !free);
    assign accept    = sym_valid && sym_ready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        ld_data = buf_q;
        ld_cnt  = cnt_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (at_last) begin
                        ld      = 1'b1;
                        ld_data[LAST_LSB +: SYM_W] = sym_data;
                        ld_cnt  = FULL_CNT;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        buf_d[int'(cnt_q) * SYM_W +: SYM_W] = sym_data;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // The symbol of the flush cycle is folded in before deciding.
                if (flush) begin
                    state_d = (cnt_d == '0) ? ENDED : FLUSH;
                end
            end
            FLUSH: begin
                // A non-zero count means the partial word is not yet handed over.
                if (cnt_q != '0) begin
                    if (free) begin
                        ld    = 1'b1;
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (out_valid && out_ready) begin
                    state_d = ENDED;
                end
            end
            ENDED: begin
                state_d = ENDED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    oci_dct_outreg #(
        .DATA_W (BUF_W),
        .CNT_W  (CNT_W)
    ) u_outreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ld),
        .data_i  (ld_data),
        .count_i (ld_cnt),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .count_o (out_count),
        .free_o  (free)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = (state_q == FLUSH);
    assign test_has_ended = (state_q == ENDED);
endmodule
